muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers.
Sits directly downstream of the register file: operands come from regfile read ports rd1/rd2.
Executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles.
Its hi/lo outputs feed the MFHI/MFLO path back to the regfile write data (wd).

---
 rtl/mips_pkg.sv | 35 +++
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the magnitude/negate helpers used around the unsigned core.
package mips_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic [MD_WIDTH-1:0] mdNeg(input logic [MD_WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*MD_WIDTH-1:0] mdNegDbl(input logic [2*MD_WIDTH-1:0] x);
    return -x;
  endfunction

  // Two's-complement magnitude when signed; the most negative value maps to itself,
  // which is still the correct unsigned magnitude.
  function automatic logic [MD_WIDTH-1:0] mdAbs(input logic [MD_WIDTH-1:0] x,
                                                input logic isSigned);
    return (isSigned && x[MD_WIDTH-1]) ? mdNeg(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the register-file read ports and the
// multiply/divide unit.
interface muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; operates on
// magnitudes for WIDTH cycles, then applies signs in a single FIX cycle.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  io_md
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state;
  md_state_e          w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_isDiv;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_isSigned;
  logic               w_lastIter;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_shRem;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;

  assign w_accept   = (r_state == IDLE) && io_md.start;
  assign w_isSigned = (io_md.op == MD_MULT) || (io_md.op == MD_DIV);
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_md.start) w_next = RUN;
      RUN:     if (w_lastIter)  w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_acc low half is the multiplier (multiply) or the dividend shifting out
  // while quotient bits shift in (divide). The trial remainder never exceeds
  // WIDTH+1 bits, so the borrow bit of w_diff is the restore decision.
  always_comb begin
    w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_shRem   = {r_rem, r_acc[WIDTH-1]};
    w_diff    = w_shRem - {1'b0, r_opnd};
    w_prodFix = r_negRes ? mdNegDbl(r_acc) : r_acc;
    w_quotFix = (r_negRes && !r_divZero) ? mdNeg(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    w_remFix  = r_negRem ? mdNeg(r_rem) : r_rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_isDiv   <= io_md.op[1];
            r_negRes  <= w_isSigned && (io_md.a[WIDTH-1] ^ io_md.b[WIDTH-1]);
            r_negRem  <= w_isSigned && io_md.a[WIDTH-1];
            r_divZero <= (io_md.b == '0);
            r_cnt     <= '0;
            r_rem     <= '0;
            if (io_md.op[1]) begin
              r_acc  <= {{WIDTH{1'b0}}, mdAbs(io_md.a, w_isSigned)};
              r_opnd <= mdAbs(io_md.b, w_isSigned);
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, mdAbs(io_md.b, w_isSigned)};
              r_opnd <= mdAbs(io_md.a, w_isSigned);
            end
          end else begin
            if (io_md.mthi) r_hi <= io_md.a;
            if (io_md.mtlo) r_lo <= io_md.a;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_isDiv) begin
            if (!w_diff[WIDTH]) begin
              r_rem              <= w_diff[WIDTH-1:0];
              r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b1};
            end else begin
              r_rem              <= w_shRem[WIDTH-1:0];
              r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b0};
            end
          end else if (r_acc[0]) begin
            r_acc <= {w_mulSum, r_acc[WIDTH-1:1]};
          end else begin
            r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
          end
        end
        FIX: begin
          r_cnt  <= '0;
          r_done <= 1'b1;
          if (r_isDiv) begin
            r_hi <= w_remFix;
            r_lo <= w_quotFix;
          end else begin
            r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFix[WIDTH-1:0];
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign io_md.busy = (r_state != IDLE);
  assign io_md.done = r_done;
  assign io_md.hi   = r_hi;
  assign io_md.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   failCount  = 0;
  logic [31:0] expHi, expLo;

  muldiv_unit_if #(.WIDTH(32)) io ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_md (io)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // MIPS semantics from 64-bit / 32-bit integer arithmetic.
  function automatic void refModel(input md_op_e op, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sp;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MD_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      MD_MULT: begin
        sp = longint'(sa) * longint'(sb);
        p  = sp;
        hi = p[63:32];
        lo = p[31:0];
      end
      MD_DIVU: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0; lo = 32'h8000_0000;
        end else begin
          hi = sa % sb; lo = sa / sb;
        end
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is high.
  task automatic applyStimulus(input md_op_e op, input logic [31:0] a,
                               input logic [31:0] b, input bit disturb);
    logic [31:0] newHi, newLo;
    logic [1:0]  rop;
    int busyCnt, cycles;
    refModel(op, a, b, newHi, newLo);
    io.start = 1'b1; io.op = op; io.a = a; io.b = b;
    @(negedge clk);
    io.start = 1'b0; io.mthi = 1'b0; io.mtlo = 1'b0;
    checkOutput("hold hi at launch", {32'd0, io.hi}, {32'd0, expHi});
    checkOutput("hold lo at launch", {32'd0, io.lo}, {32'd0, expLo});
    busyCnt = 0;
    cycles  = 0;
    while (!io.done && cycles < 40) begin
      if (io.busy) busyCnt++;
      if (disturb && cycles < 30) begin
        rop     = 2'($urandom_range(3, 0));
        io.op   = md_op_e'(rop);
        io.a    = (cycles == 8) ? 32'hAAAA_0000 : $urandom;
        io.b    = $urandom;
        io.start = (cycles == 5);
        io.mthi  = (cycles == 8);
        io.mtlo  = (cycles == 9);
        if (cycles == 12)
          checkOutput("hold hi while busy", {32'd0, io.hi}, {32'd0, expHi});
      end
      @(negedge clk);
      cycles++;
    end
    io.start = 1'b0; io.mthi = 1'b0; io.mtlo = 1'b0;
    expHi = newHi;
    expLo = newLo;
    checkOutput("done seen", {63'd0, io.done}, 64'd1);
    checkOutput("busy cycles", 64'(busyCnt), 64'd33);
    checkOutput("busy low at done", {63'd0, io.busy}, 64'd0);
    checkOutput("hi result", {32'd0, io.hi}, {32'd0, expHi});
    checkOutput("lo result", {32'd0, io.lo}, {32'd0, expLo});
  endtask

  task automatic checkDoneDrop();
    @(negedge clk);
    checkOutput("done one cycle", {63'd0, io.done}, 64'd0);
    checkOutput("hi hold after done", {32'd0, io.hi}, {32'd0, expHi});
    checkOutput("lo hold after done", {32'd0, io.lo}, {32'd0, expLo});
  endtask

  task automatic moveTo(input bit toHi, input bit toLo, input logic [31:0] val);
    io.mthi = toHi; io.mtlo = toLo; io.a = val;
    @(negedge clk);
    io.mthi = 1'b0; io.mtlo = 1'b0;
    if (toHi) expHi = val;
    if (toLo) expLo = val;
    checkOutput("mthi/mtlo hi", {32'd0, io.hi}, {32'd0, expHi});
    checkOutput("mthi/mtlo lo", {32'd0, io.lo}, {32'd0, expLo});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    bit          sawDone;
    rst = 1'b1;
    io.start = 1'b0; io.op = MD_MULT; io.a = '0; io.b = '0;
    io.mthi = 1'b0; io.mtlo = 1'b0;
    expHi = '0; expLo = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {63'd0, io.busy}, 64'd0);
    checkOutput("reset done", {63'd0, io.done}, 64'd0);
    checkOutput("reset hi", {32'd0, io.hi}, 64'd0);
    checkOutput("reset lo", {32'd0, io.lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("multu max hi", {32'd0, io.hi}, 64'hFFFF_FFFE);
    checkDoneDrop();
    applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    checkOutput("mult neg lo", {32'd0, io.lo}, 64'hFFFF_FFEB);
    applyStimulus(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    checkOutput("mult minmin hi", {32'd0, io.hi}, 64'h4000_0000);
    applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b0);
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("div neg rem", {32'd0, io.hi}, 64'hFFFF_FFFF);
    applyStimulus(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    checkOutput("div neg quot", {32'd0, io.lo}, 64'hFFFF_FFFD);
    applyStimulus(MD_DIV, 32'h1234_5678, 32'd0, 1'b0);
    checkOutput("div by zero lo", {32'd0, io.lo}, 64'hFFFF_FFFF);
    applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checkOutput("div overflow lo", {32'd0, io.lo}, 64'h8000_0000);
    checkDoneDrop();

    applyStimulus(MD_MULTU, 32'd5, 32'd6, 1'b1);
    checkOutput("ignored start lo", {32'd0, io.lo}, 64'd30);
    checkDoneDrop();
    moveTo(1'b1, 1'b0, 32'hDEAD_BEEF);
    moveTo(1'b0, 1'b1, 32'h0BAD_F00D);
    moveTo(1'b1, 1'b1, 32'h1357_9BDF);
    io.mtlo = 1'b1;
    applyStimulus(MD_MULTU, 32'h11, 32'd2, 1'b0);
    checkDoneDrop();

    // Reset in the middle of a DIVU: the result must never appear.
    io.start = 1'b1; io.op = MD_DIVU; io.a = 32'd1000; io.b = 32'd3;
    @(negedge clk);
    io.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expHi = '0; expLo = '0;
    checkOutput("mid rst busy", {63'd0, io.busy}, 64'd0);
    checkOutput("mid rst done", {63'd0, io.done}, 64'd0);
    checkOutput("mid rst hi", {32'd0, io.hi}, 64'd0);
    checkOutput("mid rst lo", {32'd0, io.lo}, 64'd0);
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (io.done) sawDone = 1'b1;
    end
    checkOutput("no done after rst", {63'd0, sawDone}, 64'd0);

    applyStimulus(MD_MULTU, 32'd3, 32'd4, 1'b0);
    checkOutput("post rst lo", {32'd0, io.lo}, 64'd12);
    applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b0);
    checkOutput("back to back lo", {32'd0, io.lo}, 64'd14);

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(3, 0));
      ra  = $urandom;
      case ($urandom_range(4, 0))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(15, 1));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (i % 7 == 3) ra = 32'h8000_0000;
      applyStimulus(md_op_e'(rop), ra, rb, bit'(i % 2));
    end
    checkDoneDrop();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
